uart_tx_mmio: RTL and testbench

// - Memory-mapped UART transmitter on the core's data-memory bus, downstream of core stores.
// - The SoC routes the core's dmem_* signals to this block in parallel with data_mem.
// - sel_o tells the SoC to mux rdata_o over data_mem's read data.
// - Bytes stored to TXDATA queue in a FIFO and serialise as 8N1 frames on tx_o for debug output.

---
 rtl/uart_tx_mmio_pkg.sv | 38 +++
 rtl/uart_tx_mmio_if.sv | 27 ++
 rtl/uart_tx_mmio_sync_fifo.sv | 55 +++++
 rtl/uart_tx_mmio.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// ============================================================================
// Module  : uart_tx_mmio_pkg
// Brief   : Register offsets, STATUS bit positions and TX FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_tx_mmio_pkg;

    localparam logic [2:0] UART_TXDATA_OFS = 3'd0;
    localparam logic [2:0] UART_STATUS_OFS = 3'd4;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [31:0] status_word(input logic full, input logic empty,
                                                input logic busy, input logic ovf);
        logic [31:0] w;
        w                 = '0;
        w[STAT_FULL_BIT]  = full;
        w[STAT_EMPTY_BIT] = empty;
        w[STAT_BUSY_BIT]  = busy;
        w[STAT_OVF_BIT]   = ovf;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
// ============================================================================
// Module  : uart_tx_mmio_if
// Brief   : Data-memory bus slice seen by the UART register window.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_tx_mmio_if;
    logic        wen_i;
    logic [2:0]  mask_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        sel_o;

    modport master (
        output wen_i, mask_i, addr_i, wdata_i,
        input  rdata_o, sel_o
    );

    modport slave (
        input  wen_i, mask_i, addr_i, wdata_i,
        output rdata_o, sel_o
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_mmio_sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with extra-MSB pointers; dout is a combinational
//           read of the head entry.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic             clk_i,
    input  wire logic             reset_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] din_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign dout_o  = r_mem[r_rptr[AW-1:0]];

    // A pop frees the head slot this edge, so a push into a full FIFO is legal then.
    assign w_rd = pop_i && !empty_o;
    assign w_wr = push_i && (!full_o || w_rd);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= din_i;
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ============================================================================
// Module  : uart_tx_mmio
// Brief   : Memory-mapped 8N1 UART transmitter with TX FIFO and sticky overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int          CLK_FREQ   = 1_000_000,
    parameter int          BAUD       = 9600,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400
) (
    input  wire logic      clk_i,
    input  wire logic      reset_i,
    uart_tx_mmio_if.slave  bus,
    output logic           tx_o,
    output logic           busy_o
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0] c_BAUD_LAST = BW'(CPB - 1);

    tx_state_t   r_state, w_state_nxt;
    logic [BW-1:0] r_baud, w_baud_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_ovf;

    logic        w_sel, w_hit_tx, w_hit_st;
    logic        w_push_req, w_push_ok, w_pop;
    logic        w_full, w_empty;
    logic [7:0]  w_dout;
    logic        w_baud_done;
    logic        w_unused;

    // ------------------------------------------------------------------ decode
    assign w_sel      = (bus.addr_i[31:3] == BASE_ADDR[31:3]);
    assign w_hit_tx   = w_sel && (bus.addr_i[2:0] == UART_TXDATA_OFS);
    assign w_hit_st   = w_sel && (bus.addr_i[2:0] == UART_STATUS_OFS);
    assign w_push_req = bus.wen_i && w_hit_tx;
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    assign bus.sel_o   = w_sel;
    assign bus.rdata_o = w_hit_st ? status_word(w_full, w_empty, busy_o, r_ovf) : '0;
    assign busy_o      = (r_state != ST_IDLE) || !w_empty;
    assign tx_o        = r_tx;

    assign w_unused = &{1'b0, bus.mask_i, bus.wdata_i[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push_ok),
        .din_i   (bus.wdata_i[7:0]),
        .pop_i   (w_pop),
        .dout_o  (w_dout),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Set beats clear when a dropped push and a STATUS clear land together.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ovf <= 1'b0;
        end else if (w_push_req && !w_push_ok) begin
            r_ovf <= 1'b1;
        end else if (bus.wen_i && w_hit_st && bus.wdata_i[STAT_OVF_BIT]) begin
            r_ovf <= 1'b0;
        end
    end

    // -------------------------------------------------------------- TX engine
    assign w_baud_done = (r_baud == c_BAUD_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_dout;
                    w_baud_nxt  = '0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit so frames abut.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_dout;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + BW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Line level is registered, derived from where the FSM is heading.
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// ============================================================================
// Module  : tb_uart_tx_mmio
// Brief   : Randomised bench with a frame-position reference model of the UART.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_mmio;

    localparam logic [31:0] c_BASE  = 32'h0000_0400;
    localparam int          c_CPB   = 16;
    localparam int          c_DEPTH = 8;
    localparam int          c_FRAME = 10 * c_CPB;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic busy;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (c_DEPTH),
        .BASE_ADDR  (c_BASE)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave),
        .tx_o    (tx),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Reference model: byte queue plus position inside the frame on the line.
    logic [7:0] m_q[$];
    bit         m_active = 0;
    int         m_pos    = 0;
    logic [7:0] m_cur    = 8'h00;
    bit         m_ovf    = 0;

    task automatic model_edge(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d);
        bit push_req, clr, last, pop, accept;
        if (r) begin
            m_q.delete();
            m_active = 0;
            m_pos    = 0;
            m_ovf    = 0;
            return;
        end
        push_req = w && (a == c_BASE);
        clr      = w && (a == c_BASE + 32'd4) && d[3];
        last     = m_active && (m_pos == c_FRAME - 1);
        pop      = (m_q.size() > 0) && (!m_active || last);
        accept   = push_req && ((m_q.size() < c_DEPTH) || pop);
        if (push_req && !accept) m_ovf = 1;
        else if (clr)            m_ovf = 0;
        if (m_active) begin
            if (last) m_active = 0;
            else      m_pos++;
        end
        if (pop) begin
            m_cur    = m_q.pop_front();
            m_active = 1;
            m_pos    = 0;
        end
        if (accept) m_q.push_back(d[7:0]);
    endtask

    function automatic logic exp_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_pos / c_CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    function automatic logic exp_busy();
        return m_active || (m_q.size() > 0);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [31:0] s;
        s = '0;
        if (a == c_BASE + 32'd4) begin
            s[0] = (m_q.size() == c_DEPTH);
            s[1] = (m_q.size() == 0);
            s[2] = exp_busy();
            s[3] = m_ovf;
        end
        return s;
    endfunction

    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
        logic [31:0] sel_exp;
        rst         = r;
        bus.wen_i   = w;
        bus.addr_i  = a;
        bus.wdata_i = d;
        bus.mask_i  = 3'($urandom);
        @(posedge clk);
        model_edge(r, w, a, d);
        #1;
        sel_exp = {31'd0, a[31:3] == c_BASE[31:3]};
        chk("tx",    {31'd0, tx},        {31'd0, exp_tx()});
        chk("busy",  {31'd0, busy},      {31'd0, exp_busy()});
        chk("sel",   {31'd0, bus.sel_o}, sel_exp);
        chk("rdata", bus.rdata_o,        exp_rdata(a));
    endtask

    task automatic idle(input int n, input logic [31:0] a);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, 32'($urandom));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          sel;

        // Reset and STATUS after reset
        step(1'b1, 1'b0, c_BASE + 32'd4, 32'd0);
        step(1'b1, 1'b0, c_BASE + 32'd4, 32'd0);
        step(1'b0, 1'b0, c_BASE + 32'd4, 32'd0);
        chk("rst_status", bus.rdata_o, 32'h2);
        chk("rst_sel",    {31'd0, bus.sel_o}, 32'd1);
        chk("rst_tx",     {31'd0, tx}, 32'd1);
        chk("rst_busy",   {31'd0, busy}, 32'd0);

        // Single 0x55 frame
        step(1'b0, 1'b1, c_BASE, 32'h0000_0055);
        step(1'b0, 1'b0, c_BASE + 32'd4, 32'd0);
        chk("frame_start", {31'd0, tx}, 32'd0);
        idle(175, c_BASE + 32'd4);
        chk("frame_done_busy", {31'd0, busy}, 32'd0);

        // Nine back-to-back writes fill the FIFO, tenth overflows, then clear
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, c_BASE, 32'($urandom));
        step(1'b0, 1'b0, c_BASE + 32'd4, 32'd0);
        chk("fill_status", bus.rdata_o, 32'h5);
        step(1'b0, 1'b1, c_BASE, 32'($urandom));
        step(1'b0, 1'b0, c_BASE + 32'd4, 32'd0);
        chk("ovf_status", bus.rdata_o, 32'hD);
        step(1'b0, 1'b1, c_BASE + 32'd4, 32'h0000_0008);
        chk("ovf_clear", bus.rdata_o, 32'h5);
        idle(9 * c_FRAME + 20, c_BASE + 32'd4);
        chk("drain_status", bus.rdata_o, 32'h2);

        // Reset mid-DATA of a 3-byte burst
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, c_BASE, 32'($urandom));
        idle(40, c_BASE + 32'd4);
        step(1'b1, 1'b0, c_BASE + 32'd4, 32'd0);
        chk("midrst_tx",     {31'd0, tx}, 32'd1);
        chk("midrst_status", bus.rdata_o, 32'h2);
        idle(4 * c_FRAME, c_BASE + 32'd4);
        chk("midrst_quiet", {31'd0, tx}, 32'd1);

        // Writes outside TXDATA have no effect
        step(1'b0, 1'b1, c_BASE + 32'd8, 32'h0000_00AA);
        step(1'b0, 1'b1, 32'h0, 32'h0000_00AA);
        chk("unsel_sel",   {31'd0, bus.sel_o}, 32'd0);
        chk("unsel_rdata", bus.rdata_o, 32'd0);
        step(1'b0, 1'b0, c_BASE + 32'd8, 32'd0);
        chk("ofs8_rdata", bus.rdata_o, 32'd0);
        step(1'b0, 1'b0, c_BASE + 32'd4, 32'd0);
        chk("unsel_status", bus.rdata_o, 32'h2);
        chk("unsel_tx",     {31'd0, tx}, 32'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 5000; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: a = c_BASE;
                3, 4, 9: a = c_BASE + 32'd4;
                5:       a = c_BASE + 32'd8;
                6:       a = 32'h0;
                7:       a = $urandom;
                default: a = c_BASE + 32'($urandom_range(1, 7));
            endcase
            d = $urandom;
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 99) < 8), a, d);
        end
        idle(c_DEPTH * c_FRAME + 200, c_BASE + 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
